jk_excite_seq: RTL and testbench

//  Drive side of a bank of WIDTH jk_ff-style flip-flops. Accepts a target word on a

---
 rtl/jk_excite_seq.sv | 146 ++++++++++++++
 tb/tb_jk_excite_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_seq.sv
// ----------------------------------------------------------------------------
// jk_excite_seq
//   Drive side of a bank of WIDTH JK flip-flops. A target word is accepted on
//   a valid/ready handshake, per-bit J/K excitation is derived from the bank's
//   current q, J/K are pulsed for one clock, and the bank's q is then compared
//   against the target. A mismatch is retried up to MAX_RETRY extra times
//   before an error pulse is raised.
//
//   State table
//     state  | meaning
//     IDLE   | waiting for a target; tgt_ready_o high once out of reset
//     DRIVE  | j_o/k_o presented to the bank, sampled at the closing edge
//     SETTLE | bank q compared with the latched target at the closing edge
//
// Ports
//   clk          rising-edge clock, shared with the JK bank
//   reset        asynchronous, active-low reset
//   tgt_valid_i  target word valid
//   tgt_i        target word
//   tgt_ready_o  block can accept a target
//   q_fb_i       q of the JK bank (feedback)
//   j_o, k_o     J and K inputs to the JK bank
//   busy_o       sequence in progress (state != IDLE)
//   done_o       one-cycle pulse: bank q matched the target
//   err_o        one-cycle pulse: retries exhausted, bank q != target
// ----------------------------------------------------------------------------
module jk_excite_seq #(
    parameter int WIDTH      = 8,
    parameter bit USE_TOGGLE = 1'b0,
    parameter int MAX_RETRY  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid_i,
    input  logic [WIDTH-1:0] tgt_i,
    output logic             tgt_ready_o,
    input  logic [WIDTH-1:0] q_fb_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_q, tgt_nxt;
    logic [2:0]       cnt_q, cnt_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic             ready_nxt, busy_nxt, done_nxt, err_nxt;

    // Excitation is computed against the incoming word while idle (load on
    // accept) and against the latched word during a retry reload.
    logic [WIDTH-1:0] cmp_tgt, diff, exc_j, exc_k;

    always_comb begin
        cmp_tgt = (state == IDLE) ? tgt_i : tgt_q;
        diff    = q_fb_i ^ cmp_tgt;
        if (USE_TOGGLE) begin
            exc_j = diff;
            exc_k = diff;
        end else begin
            exc_j = diff & cmp_tgt;
            exc_k = diff & ~cmp_tgt;
        end
    end

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        cnt_nxt   = cnt_q;
        j_nxt     = '0;
        k_nxt     = '0;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (tgt_valid_i && tgt_ready_o) begin
                    tgt_nxt   = tgt_i;
                    cnt_nxt   = 3'd0;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    ready_nxt = 1'b0;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (q_fb_i == tgt_q) begin
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q < RETRY_MAX) begin
                    cnt_nxt   = cnt_q + 3'd1;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    state_nxt = DRIVE;
                end else begin
                    err_nxt   = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tgt_q       <= '0;
            cnt_q       <= 3'd0;
            j_o         <= '0;
            k_o         <= '0;
            tgt_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            tgt_q       <= tgt_nxt;
            cnt_q       <= cnt_nxt;
            j_o         <= j_nxt;
            k_o         <= k_nxt;
            tgt_ready_o <= ready_nxt;
            busy_o      <= busy_nxt;
            done_o      <= done_nxt;
            err_o       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_excite_seq.sv
// ----------------------------------------------------------------------------
// tb_jk_excite_seq
//   Two sequencer instances (set/reset and toggle excitation), each paired with
//   a behavioural 8-bit JK bank. Bank 0 has a preload port and a stuck-at-0
//   option on bit 0 to force retries.
// ----------------------------------------------------------------------------
module tb_jk_excite_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [7:0] tgt0 = '0, tgt1 = '0;
    logic       ready0, ready1, busy0, busy1, done0, done1, err0, err1;
    logic [7:0] j0, k0, j1, k1, q0, q1;
    logic [7:0] bank0, bank1;
    logic       ld0 = 1'b0, ld1 = 1'b0, stuck0 = 1'b0;
    logic [7:0] ldv0 = '0, ldv1 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jk_excite_seq #(.WIDTH(8), .USE_TOGGLE(1'b0), .MAX_RETRY(2)) u_dut0 (
        .clk(clk), .reset(reset), .tgt_valid_i(valid0), .tgt_i(tgt0),
        .tgt_ready_o(ready0), .q_fb_i(q0), .j_o(j0), .k_o(k0),
        .busy_o(busy0), .done_o(done0), .err_o(err0));

    jk_excite_seq #(.WIDTH(8), .USE_TOGGLE(1'b1), .MAX_RETRY(2)) u_dut1 (
        .clk(clk), .reset(reset), .tgt_valid_i(valid1), .tgt_i(tgt1),
        .tgt_ready_o(ready1), .q_fb_i(q1), .j_o(j1), .k_o(k1),
        .busy_o(busy1), .done_o(done1), .err_o(err1));

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank0 <= '0;
            bank1 <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                case ({j0[i], k0[i]})
                    2'b01:   bank0[i] <= 1'b0;
                    2'b10:   bank0[i] <= 1'b1;
                    2'b11:   bank0[i] <= ~bank0[i];
                    default: bank0[i] <= bank0[i];
                endcase
                case ({j1[i], k1[i]})
                    2'b01:   bank1[i] <= 1'b0;
                    2'b10:   bank1[i] <= 1'b1;
                    2'b11:   bank1[i] <= ~bank1[i];
                    default: bank1[i] <= bank1[i];
                endcase
            end
            if (ld0) bank0 <= ldv0;
            if (ld1) bank1 <= ldv1;
        end
    end

    assign q0 = bank0 & ~{7'b0, stuck0};
    assign q1 = bank1;

    // done and err must never coincide, and neither may be high while ready is low
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if ((done0 && err0) || ((done0 || err0) && !ready0)) begin
                n_fail++;
                $display("FAIL pulse_excl: done=%b err=%b ready=%b", done0, err0, ready0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_banks(input logic [7:0] v0, input logic [7:0] v1);
        ld0 = 1'b1; ldv0 = v0;
        ld1 = 1'b1; ldv1 = v1;
        tick();
        ld0 = 1'b0; ld1 = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ready0, busy0, done0, err0, j0, k0} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 0", {ready0, busy0, done0, err0, j0, k0});
        end
        repeat (2) tick();
        n_checks++;
        if ({ready0, busy0, done0, err0, j0, k0} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", {ready0, busy0, done0, err0, j0, k0});
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 0", ready0);
        end
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release: ready=%b busy=%b want 1 0", ready0, busy0);
        end
        // abort mid-run during SETTLE
        valid0 = 1'b1; tgt0 = 8'h0F;
        tick();
        valid0 = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ready0, busy0, done0, err0, j0, k0} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_midrun: got %h want 0", {ready0, busy0, done0, err0, j0, k0});
        end
        tick();
        n_checks++;
        if ({done0, err0} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_midrun_pulse: got %b want 00", {done0, err0});
        end
        #2 reset = 1'b1;
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || busy0 !== 1'b0 || bank0 !== 8'h00) begin
            n_fail++;
            $display("FAIL rerelease: ready=%b busy=%b q=%h want 1 0 00", ready0, busy0, bank0);
        end
    endtask

    task automatic test_basic();
        valid0 = 1'b1; tgt0 = 8'hA5;
        tick();
        valid0 = 1'b0;
        n_checks++;
        if (j0 !== 8'hA5 || k0 !== 8'h00 || busy0 !== 1'b1 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drive: j=%h k=%h busy=%b ready=%b want a5 00 1 0", j0, k0, busy0, ready0);
        end
        tick();
        n_checks++;
        if (j0 !== 8'h00 || k0 !== 8'h00 || bank0 !== 8'hA5 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_settle: j=%h k=%h q=%h done=%b want 00 00 a5 0", j0, k0, bank0, done0);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b1 || err0 !== 1'b0 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b err=%b ready=%b busy=%b want 1 0 1 0", done0, err0, ready0, busy0);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b want 0", done0);
        end
    endtask

    task automatic test_excite_modes();
        load_banks(8'hF0, 8'hF0);
        valid0 = 1'b1; tgt0 = 8'h3C;
        valid1 = 1'b1; tgt1 = 8'h3C;
        tick();
        valid0 = 1'b0; valid1 = 1'b0;
        n_checks++;
        if (j0 !== 8'h0C || k0 !== 8'hC0) begin
            n_fail++;
            $display("FAIL setreset_jk: j=%h k=%h want 0c c0", j0, k0);
        end
        n_checks++;
        if (j1 !== 8'hCC || k1 !== 8'hCC) begin
            n_fail++;
            $display("FAIL toggle_jk: j=%h k=%h want cc cc", j1, k1);
        end
        tick();
        n_checks++;
        if (bank0 !== 8'h3C || bank1 !== 8'h3C) begin
            n_fail++;
            $display("FAIL modes_q: q0=%h q1=%h want 3c 3c", bank0, bank1);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || err0 !== 1'b0 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL modes_done: done=%b%b err=%b%b want 11 00", done0, done1, err0, err1);
        end
    endtask

    task automatic test_retry_err();
        int drives;
        load_banks(8'h00, 8'h00);
        stuck0 = 1'b1;
        valid0 = 1'b1; tgt0 = 8'h01;
        tick();
        valid0 = 1'b0;
        drives = (j0 == 8'h01 && k0 == 8'h00) ? 1 : 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (j0 == 8'h01 && k0 == 8'h00) drives++;
            n_checks++;
            if (err0 !== (c == 6) || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL retry_pulse c%0d: err=%b done=%b want %b 0", c, err0, done0, (c == 6));
            end
            if (c == 6) begin
                n_checks++;
                if (ready0 !== 1'b1 || busy0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL retry_ready: ready=%b busy=%b want 1 0", ready0, busy0);
                end
            end
        end
        n_checks++;
        if (drives != 3) begin
            n_fail++;
            $display("FAIL retry_drives: got %0d want 3", drives);
        end
        stuck0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        valid0 = 1'b1; tgt0 = 8'h11;
        tick();
        tgt0 = 8'h22;
        n_checks++;
        if (busy0 !== 1'b1 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept1: busy=%b ready=%b want 1 0", busy0, ready0);
        end
        tick();
        n_checks++;
        if (j0 !== 8'h00 || k0 !== 8'h00 || busy0 !== 1'b1 || bank0 !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_ignored: j=%h k=%h busy=%b q=%h want 00 00 1 11", j0, k0, busy0, bank0);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done1: done=%b ready=%b busy=%b want 1 1 0", done0, ready0, busy0);
        end
        tick();
        valid0 = 1'b0;
        n_checks++;
        if (busy0 !== 1'b1 || ready0 !== 1'b0 || j0 !== 8'h22 || k0 !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_accept2: busy=%b ready=%b j=%h k=%h want 1 0 22 11", busy0, ready0, j0, k0);
        end
        repeat (2) tick();
        n_checks++;
        if (done0 !== 1'b1 || bank0 !== 8'h22) begin
            n_fail++;
            $display("FAIL b2b_done2: done=%b q=%h want 1 22", done0, bank0);
        end
    endtask

    task automatic test_reset_in_drive();
        load_banks(8'h00, 8'h00);
        valid0 = 1'b1; tgt0 = 8'hFF;
        tick();
        valid0 = 1'b0;
        n_checks++;
        if (j0 !== 8'hFF || k0 !== 8'h00) begin
            n_fail++;
            $display("FAIL drive_pre_reset: j=%h k=%h want ff 00", j0, k0);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (j0 !== 8'h00 || k0 !== 8'h00 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL drive_abort: j=%h k=%h busy=%b done=%b err=%b want 0", j0, k0, busy0, done0, err0);
        end
        tick();
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (done0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL post_abort c%0d: done=%b err=%b busy=%b want 0", c, done0, err0, busy0);
            end
        end
        valid0 = 1'b1; tgt0 = 8'h5A;
        tick();
        valid0 = 1'b0;
        n_checks++;
        if (j0 !== 8'h5A || k0 !== 8'h00) begin
            n_fail++;
            $display("FAIL restart_jk: j=%h k=%h want 5a 00", j0, k0);
        end
        repeat (2) tick();
        n_checks++;
        if (done0 !== 1'b1 || err0 !== 1'b0 || bank0 !== 8'h5A) begin
            n_fail++;
            $display("FAIL restart_done: done=%b err=%b q=%h want 1 0 5a", done0, err0, bank0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_excite_modes();
        test_retry_err();
        test_back_to_back();
        test_reset_in_drive();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
